// File: rtl/page_sched_pkg.sv
// Shared types and constants for the ping-pong NAND page read scheduler.
package page_sched_pkg;

  localparam int PAGE_AW = 24;

  typedef enum logic [1:0] {
    IDLE,
    CHECK,
    RUN,
    FINISH
  } top_state_t;

  typedef enum logic [1:0] {
    BANK_EMPTY,
    BANK_FULL,
    BANK_DRAINING
  } bank_state_t;

endpackage

// File: rtl/pp_bank_ctrl.sv
// One ping-pong bank: EMPTY -> FULL (filled) -> DRAINING (tx started) -> EMPTY (tx done).
module pp_bank_ctrl
  import page_sched_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        clear,
  input  logic        fill_done,
  input  logic        drain_start,
  input  logic        drain_done,
  output bank_state_t state
);

  bank_state_t state_next;

  always_comb begin
    state_next = state;
    if (clear) begin
      state_next = BANK_EMPTY;
    end else begin
      case (state)
        BANK_EMPTY:    if (fill_done)   state_next = BANK_FULL;
        BANK_FULL:     if (drain_start) state_next = BANK_DRAINING;
        BANK_DRAINING: if (drain_done)  state_next = BANK_EMPTY;
        default:                        state_next = BANK_EMPTY;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= BANK_EMPTY;
    else      state <= state_next;
  end

endmodule

// File: rtl/page_read_sched.sv
// Schedules NAND page reads into two ping-pong banks and hands full banks to the UART drain side.
// Optional read watchdog is built only when READ_TIMEOUT_EN is defined.
module page_read_sched
  import page_sched_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 1048576
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic [PAGE_AW-1:0] start_page,
  input  logic [PAGE_AW-1:0] end_page,
  input  logic               abort,
  output logic               en_read,
  output logic [PAGE_AW-1:0] read_addr,
  input  logic               end_read,
  output logic               change_ram,
  output logic               tx_start,
  output logic               tx_bank,
  input  logic               tx_done,
  output logic               busy,
  output logic               done,
  output logic               err
);

  top_state_t  state, state_next;
  bank_state_t bank_state [2];

  // One extra bit so end_page = all-ones ends without wrapping.
  logic [PAGE_AW:0] cur_page, last_page;
  logic en_read_reg, change_ram_reg, drain_sel, done_reg, err_reg;
  logic timeout_hit, abort_now, range_bad, pages_left;
  logic fill_ack, drain_go, drain_ack, all_idle, drain_phase;

  assign range_bad   = cur_page > last_page;
  assign pages_left  = cur_page <= last_page;
  assign abort_now   = (state != IDLE) && (abort || timeout_hit);
  assign drain_phase = (state == RUN) || (state == FINISH);
  assign fill_ack    = (state == RUN) && en_read_reg && end_read && !abort_now;
  assign drain_go    = drain_phase && (bank_state[drain_sel] == BANK_FULL) && !abort_now;
  assign drain_ack   = drain_phase && (bank_state[drain_sel] == BANK_DRAINING) && tx_done && !abort_now;
  assign all_idle    = !pages_left && !en_read_reg &&
                       (bank_state[0] == BANK_EMPTY) && (bank_state[1] == BANK_EMPTY);

`ifdef READ_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  logic [TW-1:0] wait_cnt;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst)                         wait_cnt <= '0;
    else if (!en_read_reg || end_read) wait_cnt <= '0;
    else                              wait_cnt <= wait_cnt + 1'b1;
  end

  assign timeout_hit = en_read_reg && !end_read && (wait_cnt == TW'(TIMEOUT_CYCLES - 1));
`else
  // No watchdog: the request waits for end_read indefinitely.
  assign timeout_hit = (TIMEOUT_CYCLES < 0);
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (start) state_next = CHECK;
      CHECK:   state_next = (abort_now || range_bad) ? IDLE : RUN;
      RUN:     if (abort_now) state_next = IDLE;
               else if (all_idle) state_next = FINISH;
      FINISH:  state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    busy       = (state != IDLE);
    tx_start   = drain_go;
    tx_bank    = drain_sel;
    en_read    = en_read_reg;
    read_addr  = cur_page[PAGE_AW-1:0];
    change_ram = change_ram_reg;
    done       = done_reg;
    err        = err_reg;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cur_page       <= '0;
      last_page      <= '0;
      en_read_reg    <= 1'b0;
      change_ram_reg <= 1'b0;
      drain_sel      <= 1'b0;
      done_reg       <= 1'b0;
      err_reg        <= 1'b0;
    end else begin
      done_reg <= 1'b0;
      err_reg  <= 1'b0;
      if (state == IDLE && start) begin
        cur_page  <= {1'b0, start_page};
        last_page <= {1'b0, end_page};
      end
      if (abort_now) begin
        en_read_reg <= 1'b0;
        err_reg     <= 1'b0 | 1'b1;
      end else begin
        if (state == CHECK) begin
          change_ram_reg <= 1'b0;
          drain_sel      <= 1'b0;
          if (range_bad) err_reg <= 1'b1;
          else           en_read_reg <= 1'b1;
        end
        // Fill side: one cycle gap after each page so the next bank is re-evaluated.
        if (fill_ack) begin
          en_read_reg    <= 1'b0;
          cur_page       <= cur_page + 1'b1;
          change_ram_reg <= ~change_ram_reg;
        end else if (state == RUN && !en_read_reg && pages_left &&
                     bank_state[change_ram_reg] == BANK_EMPTY) begin
          en_read_reg <= 1'b1;
        end
        if (drain_ack) drain_sel <= ~drain_sel;
        if (state == FINISH) done_reg <= 1'b1;
      end
    end
  end

  for (genvar gi = 0; gi < 2; gi++) begin : g_bank
    pp_bank_ctrl u_bank (
      .clk         (clk),
      .rst         (rst),
      .clear       (abort_now || state == CHECK),
      .fill_done   (fill_ack && (change_ram_reg == 1'(gi))),
      .drain_start (drain_go && (drain_sel == 1'(gi))),
      .drain_done  (drain_ack && (drain_sel == 1'(gi))),
      .state       (bank_state[gi])
    );
  end

endmodule

// File: tb/tb_page_read_sched.sv
// Directed scoreboard bench for page_read_sched; the timeout case follows READ_TIMEOUT_EN.
module tb_page_read_sched;

  logic        clk = 1'b0, rst = 1'b0, start = 1'b0, abort = 1'b0;
  logic        end_read = 1'b0, tx_done = 1'b0;
  logic [23:0] start_page = '0, end_page = '0;
  logic        en_read, change_ram, tx_start, tx_bank, busy, done, err;
  logic [23:0] read_addr;

  page_read_sched #(.TIMEOUT_CYCLES(16)) dut (
    .clk(clk), .rst(rst), .start(start), .start_page(start_page), .end_page(end_page),
    .abort(abort), .en_read(en_read), .read_addr(read_addr), .end_read(end_read),
    .change_ram(change_ram), .tx_start(tx_start), .tx_bank(tx_bank), .tx_done(tx_done),
    .busy(busy), .done(done), .err(err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [23:0] addr;
    logic        bank;
  } rd_exp_t;

  rd_exp_t exp_rd[$];
  logic    exp_tx[$];
  int      exp_evt[$];   // 1 = done, 2 = err

  int tests = 0, fails = 0, cyc = 0;
  int rd_rises = 0, tx_count = 0, rd_rise_cyc = 0, tx_cyc = 0, err_cyc = 0, er_cyc = 0;
  int start_cyc = 0, rd_base = 0, tx_base = 0;
  logic rd_auto = 1'b0, tx_auto = 1'b0, rd_kick = 1'b0, tx_kick = 1'b0;
  int   tx_lat = 1, tx_cnt = 0;
  logic en_prev = 1'b0;
  rd_exp_t mon_rd;
  logic    mon_tx;
  int      mon_ev;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    tests++;
    assert (obs === expv) else begin
      fails++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, expv);
    end
  endtask

  task automatic push_rd(input logic [23:0] a, input logic b);
    rd_exp_t e;
    e.addr = a;
    e.bank = b;
    exp_rd.push_back(e);
  endtask

  // Monitor: pops the scoreboard whenever the DUT produces a transaction.
  always @(negedge clk) begin
    if (rst) begin
      if (en_read && !en_prev) begin
        rd_rises++;
        rd_rise_cyc = cyc;
        $display("[TB] cyc %0d en_read addr=%06h change_ram=%0d", cyc, read_addr, change_ram);
        chk("rd_expected", exp_rd.size() != 0, 1);
        if (exp_rd.size() != 0) begin
          mon_rd = exp_rd.pop_front();
          chk("read_addr", read_addr, mon_rd.addr);
          chk("change_ram", change_ram, mon_rd.bank);
        end
      end
      if (tx_start) begin
        tx_count++;
        tx_cyc = cyc;
        $display("[TB] cyc %0d tx_start bank=%0d", cyc, tx_bank);
        chk("tx_expected", exp_tx.size() != 0, 1);
        if (exp_tx.size() != 0) begin
          mon_tx = exp_tx.pop_front();
          chk("tx_bank", tx_bank, mon_tx);
        end
      end
      if (done || err) begin
        if (err) err_cyc = cyc;
        $display("[TB] cyc %0d event done=%0d err=%0d", cyc, done, err);
        chk("evt_expected", exp_evt.size() != 0, 1);
        if (exp_evt.size() != 0) begin
          mon_ev = exp_evt.pop_front();
          chk("evt_kind", done ? 1 : 2, mon_ev);
        end
      end
    end
    en_prev = en_read;
  end

  // Responders for the NAND reader and UART sides.
  initial begin
    forever begin
      @(negedge clk);
      if (rd_kick) begin
        end_read = 1'b1; rd_kick = 1'b0; er_cyc = cyc;
      end else if (rd_auto && en_read && !end_read) begin
        end_read = 1'b1; er_cyc = cyc;
      end else begin
        end_read = 1'b0;
      end
      tx_done = 1'b0;
      if (tx_kick) begin
        tx_done = 1'b1; tx_kick = 1'b0;
      end else if (tx_cnt > 0) begin
        tx_cnt--;
        if (tx_cnt == 0) tx_done = 1'b1;
      end
      if (tx_start && tx_auto) tx_cnt = tx_lat;
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog expired at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  task automatic sync();
    @(posedge clk);
    #1;
  endtask

  task automatic do_start(input logic [23:0] s, input logic [23:0] e, input logic ab);
    @(negedge clk);
    start = 1'b1; start_page = s; end_page = e; abort = ab; start_cyc = cyc;
    @(negedge clk);
    start = 1'b0; abort = 1'b0;
  endtask

  task automatic wait_idle(input int budget);
    int n = 0;
    @(negedge clk);
    while (busy && n < budget) begin
      @(negedge clk);
      n++;
    end
    chk("idle_reached", busy, 0);
    repeat (2) @(negedge clk);
  endtask

  task automatic wait_en(input int budget);
    int n = 0;
    while (!en_read && n < budget) begin
      sync();
      n++;
    end
    chk("en_wait", en_read, 1);
  endtask

  task automatic kick_rd();
    rd_kick = 1'b1;
    sync();
  endtask

  task automatic chk_queues(input string tag);
    chk({tag, "_rdq"}, exp_rd.size(), 0);
    chk({tag, "_txq"}, exp_tx.size(), 0);
    chk({tag, "_evq"}, exp_evt.size(), 0);
  endtask

  initial begin
    // Reset: every output low while rst is asserted
    repeat (3) @(negedge clk);
    chk("rst_en_read", en_read, 0);
    chk("rst_read_addr", read_addr, 0);
    chk("rst_change_ram", change_ram, 0);
    chk("rst_tx_start", tx_start, 0);
    chk("rst_tx_bank", tx_bank, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_err", err, 0);
    rst = 1'b1;
    repeat (3) @(negedge clk);
    chk("post_rst_busy", busy, 0);
    chk("post_rst_en", en_read, 0);

    // Single page; abort in the same IDLE cycle as start must be ignored
    sync();
    rd_auto = 1'b1; tx_auto = 1'b1; tx_lat = 2;
    push_rd(24'h000010, 1'b0); exp_tx.push_back(1'b0); exp_evt.push_back(1);
    do_start(24'h000010, 24'h000010, 1'b1);
    wait_idle(200);
    chk("t1_start_to_en", rd_rise_cyc - start_cyc, 2);
    chk("t1_end_to_tx", tx_cyc - er_cyc, 1);
    chk_queues("t1");

    // Five pages with immediate end_read; stall while both banks busy
    sync();
    rd_auto = 1'b1; tx_auto = 1'b0; rd_base = rd_rises;
    push_rd(24'h000100, 1'b0); push_rd(24'h000101, 1'b1); exp_tx.push_back(1'b0);
    do_start(24'h000100, 24'h000104, 1'b0);
    repeat (12) @(negedge clk);
    chk("t2_stall_en", en_read, 0);
    chk("t2_stall_busy", busy, 1);
    chk("t2_stall_rises", rd_rises - rd_base, 2);
    push_rd(24'h000102, 1'b0); push_rd(24'h000103, 1'b1); push_rd(24'h000104, 1'b0);
    exp_tx.push_back(1'b1); exp_tx.push_back(1'b0); exp_tx.push_back(1'b1); exp_tx.push_back(1'b0);
    exp_evt.push_back(1);
    do_start(24'h000900, 24'h000900, 1'b0);   // ignored while busy
    sync();
    tx_auto = 1'b1; tx_lat = 3; tx_kick = 1'b1;
    wait_idle(300);
    chk("t2_rises", rd_rises - rd_base, 5);
    chk_queues("t2");

    // Range error
    sync();
    rd_base = rd_rises;
    exp_evt.push_back(2);
    do_start(24'h000005, 24'h000004, 1'b0);
    wait_idle(20);
    chk("t3_err_lat", err_cyc - start_cyc, 2);
    chk("t3_no_read", rd_rises - rd_base, 0);
    chk_queues("t3");

    // end_read and tx_done together on page 2 of 4
    sync();
    rd_auto = 1'b0; tx_auto = 1'b0; tx_base = tx_count;
    push_rd(24'h000200, 1'b0); push_rd(24'h000201, 1'b1);
    push_rd(24'h000202, 1'b0); push_rd(24'h000203, 1'b1);
    exp_tx.push_back(1'b0); exp_tx.push_back(1'b1); exp_tx.push_back(1'b0); exp_tx.push_back(1'b1);
    exp_evt.push_back(1);
    do_start(24'h000200, 24'h000203, 1'b0);
    wait_en(20);
    kick_rd();
    wait_en(20);
    tx_kick = 1'b1;
    kick_rd();
    rd_auto = 1'b1; tx_auto = 1'b1; tx_lat = 2;
    wait_idle(300);
    chk("t4_tx_total", tx_count - tx_base, 4);
    chk_queues("t4");

    // Abort while the third page request is pending
    sync();
    rd_auto = 1'b0; tx_auto = 1'b1; tx_lat = 1; tx_base = tx_count;
    push_rd(24'h000000, 1'b0); push_rd(24'h000001, 1'b1); push_rd(24'h000002, 1'b0);
    exp_tx.push_back(1'b0); exp_tx.push_back(1'b1); exp_evt.push_back(2);
    do_start(24'h000000, 24'h00000F, 1'b0);
    wait_en(20);
    kick_rd();
    wait_en(20);
    kick_rd();
    wait_en(40);
    repeat (6) sync();
    chk("t5_pre_abort_en", en_read, 1);
    @(negedge clk) abort = 1'b1;
    @(negedge clk) abort = 1'b0;
    chk("t5_abort_en", en_read, 0);
    chk("t5_abort_err", err, 1);
    chk("t5_abort_busy", busy, 0);
    sync();
    tx_kick = 1'b1;
    repeat (4) sync();
    chk("t5_late_txdone_busy", busy, 0);
    chk("t5_tx_total", tx_count - tx_base, 2);
    chk_queues("t5a");
    rd_auto = 1'b1; tx_auto = 1'b1; tx_lat = 2;
    push_rd(24'h000020, 1'b0); exp_tx.push_back(1'b0); exp_evt.push_back(1);
    do_start(24'h000020, 24'h000020, 1'b0);
    wait_idle(200);
    chk_queues("t5b");

    // end_read withheld
    sync();
    rd_auto = 1'b0; tx_auto = 1'b0;
    push_rd(24'h000300, 1'b0);
`ifdef READ_TIMEOUT_EN
    exp_evt.push_back(2);
    do_start(24'h000300, 24'h000301, 1'b0);
    wait_idle(60);
    chk("t6_timeout_lat", err_cyc - rd_rise_cyc, 16);
`else
    do_start(24'h000300, 24'h000301, 1'b0);
    repeat (40) sync();
    chk("t6_en_held", en_read, 1);
    chk("t6_busy_held", busy, 1);
    exp_evt.push_back(2);
    @(negedge clk) abort = 1'b1;
    @(negedge clk) abort = 1'b0;
    wait_idle(10);
`endif
    chk("t6_en_low", en_read, 0);
    chk_queues("t6");

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
